// File: rtl/vga_dither_pkg.sv
// Shared constants and helpers for the VGA output dither stage: Bayer table,
// offset selection by truncation depth, and a generic RGB triple type.
package vga_dither_pkg;

    localparam int VGA_BITS     = 6;
    localparam int RGB_MAX_BITS = 16;

    // Indexed by {y, x}: (0,0)=0, (1,0)=2, (0,1)=3, (1,1)=1
    localparam logic [3:0][1:0] BAYER_2X2 = {2'd1, 2'd3, 2'd2, 2'd0};

    // Narrower channels occupy the LSBs of each field.
    typedef struct packed {
        logic [RGB_MAX_BITS-1:0] r;
        logic [RGB_MAX_BITS-1:0] g;
        logic [RGB_MAX_BITS-1:0] b;
    } rgb_t;

    function automatic logic [1:0] offset(input int d, input logic x, input logic y);
        logic [1:0] idx;
        idx = {y, x};
        case (d)
            2:       offset = BAYER_2X2[idx];
            1:       offset = {1'b0, x ^ y};
            default: offset = 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/vga_dither_out_pos.sv
// Pixel/line/frame parity tracker driving the dither phase. Parities advance
// only on ce_pix; blank edges are found against the previous sampled blanks.
module dither_pos_tracker #(
    parameter bit TEMPORAL = 1'b1
) (
    input  logic clk_sys,
    input  logic reset,
    input  logic ce_pix,
    input  logic hblank,
    input  logic vblank,
    output logic x_phase,
    output logic y_phase
);

    logic xp_q, xp_d;
    logic yp_q, yp_d;
    logic fp_q, fp_d;
    logic hb_prev_q, hb_prev_d;
    logic vb_prev_q, vb_prev_d;

    always_comb begin
        xp_d      = xp_q;
        yp_d      = yp_q;
        fp_d      = fp_q;
        hb_prev_d = hb_prev_q;
        vb_prev_d = vb_prev_q;
        if (ce_pix) begin
            hb_prev_d = hblank;
            vb_prev_d = vblank;
            xp_d      = hblank ? 1'b0 : ~xp_q;
            // vblank clears the row parity even when hblank rises in the same pixel
            if (vblank) begin
                yp_d = 1'b0;
            end else if (hblank && !hb_prev_q) begin
                yp_d = ~yp_q;
            end
            if (vblank && !vb_prev_q) begin
                fp_d = ~fp_q;
            end
        end
    end

    // Previous-blank flags reset high so a reset inside blanking is not seen as an edge.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            xp_q      <= 1'b0;
            yp_q      <= 1'b0;
            fp_q      <= 1'b0;
            hb_prev_q <= 1'b1;
            vb_prev_q <= 1'b1;
        end else begin
            xp_q      <= xp_d;
            yp_q      <= yp_d;
            fp_q      <= fp_d;
            hb_prev_q <= hb_prev_d;
            vb_prev_q <= vb_prev_d;
        end
    end

    assign x_phase = xp_q ^ (TEMPORAL & fp_q);
    assign y_phase = yp_q;

endmodule

// File: rtl/vga_dither_out.sv
// VGA output stage: 2x2 ordered dither from IN_BITS to OUT_BITS per channel,
// blank forcing, and sync delay matched to the two-stage colour pipeline.
module vga_dither_out
    import vga_dither_pkg::*;
#(
    parameter int IN_BITS  = 8,
    parameter int OUT_BITS = VGA_BITS,
    parameter bit TEMPORAL = 1'b1
) (
    input  logic                clk_sys,
    input  logic                reset,
    input  logic                ce_pix,
    input  logic [IN_BITS-1:0]  r_in,
    input  logic [IN_BITS-1:0]  g_in,
    input  logic [IN_BITS-1:0]  b_in,
    input  logic                hs_in,
    input  logic                vs_in,
    input  logic                hblank,
    input  logic                vblank,
    output logic [OUT_BITS-1:0] r_out,
    output logic [OUT_BITS-1:0] g_out,
    output logic [OUT_BITS-1:0] b_out,
    output logic                hs_out,
    output logic                vs_out
);

    localparam int D = IN_BITS - OUT_BITS;

    if (D < 0 || D > 2) begin : g_bad_width
        $error("vga_dither_out: IN_BITS-OUT_BITS must be 0, 1 or 2");
    end

    logic x_phase;
    logic y_phase;

    dither_pos_tracker #(
        .TEMPORAL (TEMPORAL)
    ) u_pos (
        .clk_sys (clk_sys),
        .reset   (reset),
        .ce_pix  (ce_pix),
        .hblank  (hblank),
        .vblank  (vblank),
        .x_phase (x_phase),
        .y_phase (y_phase)
    );

    // Stage 1 shared state: offset, blank and syncs for the captured pixel.
    logic [1:0] ofs_q, ofs_d;
    logic       blank_q, blank_d;
    logic       hs1_q, hs1_d;
    logic       vs1_q, vs1_d;
    // Stage 2 syncs.
    logic       hs2_q, hs2_d;
    logic       vs2_q, vs2_d;

    always_comb begin
        ofs_d   = ofs_q;
        blank_d = blank_q;
        hs1_d   = hs1_q;
        vs1_d   = vs1_q;
        hs2_d   = hs2_q;
        vs2_d   = vs2_q;
        if (ce_pix) begin
            ofs_d   = offset(D, x_phase, y_phase);
            blank_d = hblank | vblank;
            hs1_d   = hs_in;
            vs1_d   = vs_in;
            hs2_d   = hs1_q;
            vs2_d   = vs1_q;
        end
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            ofs_q   <= 2'd0;
            blank_q <= 1'b1;
            hs1_q   <= 1'b1;
            vs1_q   <= 1'b1;
            hs2_q   <= 1'b1;
            vs2_q   <= 1'b1;
        end else begin
            ofs_q   <= ofs_d;
            blank_q <= blank_d;
            hs1_q   <= hs1_d;
            vs1_q   <= vs1_d;
            hs2_q   <= hs2_d;
            vs2_q   <= vs2_d;
        end
    end

    logic [IN_BITS-1:0]  ch_in  [3];
    logic [OUT_BITS-1:0] ch_out [3];

    assign ch_in[0] = r_in;
    assign ch_in[1] = g_in;
    assign ch_in[2] = b_in;

    for (genvar gi = 0; gi < 3; gi++) begin : g_chan
        logic [IN_BITS-1:0]  col_q, col_d;
        logic [OUT_BITS-1:0] pix_q, pix_d;
        logic [IN_BITS:0]    sum;
        logic                unused_sum;

        always_comb begin
            col_d = col_q;
            pix_d = pix_q;
            sum   = {1'b0, col_q} + (IN_BITS+1)'(ofs_q);
            if (ce_pix) begin
                col_d = ch_in[gi];
                // Blank beats saturation; the carry bit means the dither overflowed.
                if (blank_q) begin
                    pix_d = '0;
                end else if (sum[IN_BITS]) begin
                    pix_d = '1;
                end else begin
                    pix_d = sum[IN_BITS-1:D];
                end
            end
        end

        always_ff @(posedge clk_sys) begin
            if (reset) begin
                col_q <= '0;
                pix_q <= '0;
            end else begin
                col_q <= col_d;
                pix_q <= pix_d;
            end
        end

        assign unused_sum  = ^sum;
        assign ch_out[gi]  = pix_q;
    end

    assign r_out  = ch_out[0];
    assign g_out  = ch_out[1];
    assign b_out  = ch_out[2];
    assign hs_out = hs2_q;
    assign vs_out = vs2_q;

endmodule

// File: tb/tb_vga_dither_out.sv
// Directed bench for vga_dither_out: a D=2 temporal instance and a D=0
// pass-through instance share the same stimulus stream.
module tb_vga_dither_out;

    logic clk_sys = 1'b0;
    always #5 clk_sys = ~clk_sys;

    logic       reset, ce_pix, hblank, vblank, hs_in, vs_in;
    logic [7:0] r_in, g_in, b_in;
    logic [5:0] r_out, g_out, b_out;
    logic       hs_out, vs_out;
    logic [7:0] pr_out, pg_out, pb_out;
    logic       phs_out, pvs_out;

    int n_cmp   = 0;
    int n_bad   = 0;
    int step_no = 0;

    logic [5:0]  exp_r, exp_g, exp_b;
    logic        exp_hs, exp_vs;
    logic [23:0] exp_pt;

    vga_dither_out #(.IN_BITS(8), .OUT_BITS(6), .TEMPORAL(1'b1)) dut (
        .clk_sys (clk_sys), .reset (reset), .ce_pix (ce_pix),
        .r_in (r_in), .g_in (g_in), .b_in (b_in),
        .hs_in (hs_in), .vs_in (vs_in), .hblank (hblank), .vblank (vblank),
        .r_out (r_out), .g_out (g_out), .b_out (b_out),
        .hs_out (hs_out), .vs_out (vs_out)
    );

    vga_dither_out #(.IN_BITS(8), .OUT_BITS(8), .TEMPORAL(1'b1)) dut_pt (
        .clk_sys (clk_sys), .reset (reset), .ce_pix (ce_pix),
        .r_in (r_in), .g_in (g_in), .b_in (b_in),
        .hs_in (hs_in), .vs_in (vs_in), .hblank (hblank), .vblank (vblank),
        .r_out (pr_out), .g_out (pg_out), .b_out (pb_out),
        .hs_out (phs_out), .vs_out (pvs_out)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        assert (got === want) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, got, want);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, " r"},  32'(r_out),  32'(exp_r));
        chk({tag, " g"},  32'(g_out),  32'(exp_g));
        chk({tag, " b"},  32'(b_out),  32'(exp_b));
        chk({tag, " hs"}, 32'(hs_out), 32'(exp_hs));
        chk({tag, " vs"}, 32'(vs_out), 32'(exp_vs));
        chk({tag, " pt"}, 32'({pr_out, pg_out, pb_out}), 32'(exp_pt));
        $display("%s: rgb=%h/%h/%h hs=%b vs=%b pt=%h", tag, r_out, g_out, b_out,
                 hs_out, vs_out, {pr_out, pg_out, pb_out});
    endtask

    // One ce_pix pulse; outputs then show the previous pixel's expectation.
    task automatic step(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b,
                        input logic hb, input logic vb, input logic hs, input logic vs,
                        input logic [5:0] er, input logic [5:0] eg, input logic [5:0] eb);
        r_in = r; g_in = g; b_in = b;
        hblank = hb; vblank = vb; hs_in = hs; vs_in = vs;
        ce_pix = 1'b1;
        @(posedge clk_sys); #1;
        step_no++;
        check_all($sformatf("step%0d", step_no));
        exp_r = er; exp_g = eg; exp_b = eb;
        exp_hs = hs; exp_vs = vs;
        exp_pt = (hb | vb) ? 24'h0 : {r, g, b};
    endtask

    task automatic set_reset_exp();
        exp_r = 6'h00; exp_g = 6'h00; exp_b = 6'h00;
        exp_hs = 1'b1; exp_vs = 1'b1; exp_pt = 24'h0;
    endtask

    initial begin
        reset = 1'b1; ce_pix = 1'b0;
        r_in = 8'h00; g_in = 8'h00; b_in = 8'h00;
        hblank = 1'b0; vblank = 1'b0; hs_in = 1'b1; vs_in = 1'b1;

        // Reset with ce_pix low must still initialise the outputs.
        repeat (3) @(posedge clk_sys);
        #1;
        set_reset_exp();
        check_all("reset");
        reset = 1'b0;

        // Frame 0: vblank, hblank with hsync, then a 2x2 block.
        step(8'hFF, 8'hFF, 8'hFF, 1, 1, 1, 0, 6'h00, 6'h00, 6'h00);
        step(8'hFF, 8'hFF, 8'hFF, 1, 0, 0, 1, 6'h00, 6'h00, 6'h00);
        step(8'h41, 8'hFF, 8'h42, 0, 0, 1, 1, 6'h10, 6'h3F, 6'h10);
        step(8'h41, 8'hFD, 8'hFE, 0, 0, 1, 1, 6'h10, 6'h3F, 6'h3F);
        step(8'hFF, 8'hFF, 8'hFF, 1, 0, 1, 1, 6'h00, 6'h00, 6'h00);
        step(8'h41, 8'hFF, 8'h00, 0, 0, 1, 1, 6'h11, 6'h3F, 6'h00);
        step(8'h41, 8'h00, 8'h7F, 0, 0, 1, 1, 6'h10, 6'h00, 6'h20);
        // hblank and vblank rise together: row clears, frame toggles.
        step(8'hFF, 8'hFF, 8'hFF, 1, 1, 1, 0, 6'h00, 6'h00, 6'h00);
        step(8'hFF, 8'hFF, 8'hFF, 1, 0, 1, 1, 6'h00, 6'h00, 6'h00);
        // Frame 1, row 0: phase is flipped by the frame parity.
        step(8'h41, 8'h42, 8'h00, 0, 0, 1, 1, 6'h10, 6'h11, 6'h00);
        step(8'h00, 8'hFF, 8'hFF, 0, 0, 1, 1, 6'h00, 6'h3F, 6'h3F);
        step(8'hFF, 8'hFF, 8'hFF, 1, 0, 1, 1, 6'h00, 6'h00, 6'h00);

        // ce_pix low for 5 clocks: everything holds despite changing inputs.
        ce_pix = 1'b0;
        r_in = 8'h80; g_in = 8'h80; b_in = 8'h80;
        hblank = 1'b0; vblank = 1'b0; hs_in = 1'b0; vs_in = 1'b0;
        repeat (5) @(posedge clk_sys);
        #1;
        chk("hold r",  32'(r_out),  32'h00);
        chk("hold g",  32'(g_out),  32'h3F);
        chk("hold b",  32'(b_out),  32'h3F);
        chk("hold hs", 32'(hs_out), 32'h1);
        chk("hold pt", 32'({pr_out, pg_out, pb_out}), 32'h00FFFF);
        $display("hold: rgb=%h/%h/%h hs=%b", r_out, g_out, b_out, hs_out);

        // Frame 1, row 1: alternating offsets 1 and 3, hsync low near the end.
        for (int x = 0; x < 37; x++) begin
            step(8'h41, 8'h41, 8'h41, 0, 0, (x >= 35) ? 1'b0 : 1'b1, 1,
                 (x % 2 == 0) ? 6'h10 : 6'h11,
                 (x % 2 == 0) ? 6'h10 : 6'h11,
                 (x % 2 == 0) ? 6'h10 : 6'h11);
        end

        // Reset at x=37 of the active line.
        reset = 1'b1; ce_pix = 1'b1;
        r_in = 8'h41; g_in = 8'h41; b_in = 8'h41; hs_in = 1'b0;
        @(posedge clk_sys); #1;
        set_reset_exp();
        check_all("midreset");
        reset = 1'b0;

        // After release all parities restart at 0: offsets 0 then 2.
        step(8'h43, 8'h43, 8'h43, 0, 0, 1, 1, 6'h10, 6'h10, 6'h10);
        step(8'h43, 8'h43, 8'h43, 0, 0, 1, 1, 6'h11, 6'h11, 6'h11);
        step(8'hFF, 8'hFF, 8'hFF, 1, 0, 1, 1, 6'h00, 6'h00, 6'h00);
        step(8'hFF, 8'hFF, 8'hFF, 1, 0, 1, 1, 6'h00, 6'h00, 6'h00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
